// File: rtl/button_sequencer.sv
// Turns four debounced button levels into press / repeat / release events.
// Events are arbitrated by fixed priority into a 4-deep FIFO with a valid/ready output.
module button_sequencer #(
    parameter int HOLD_DELAY    = 32500000,
    parameter int REPEAT_PERIOD = 6500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] clean,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [3:0] evt_code,
    output logic       overflow
);

    // state | meaning: IDLE released | WAIT held, timing first repeat | REPEAT held, auto-repeating
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [1:0]  EV_PRESS    = 2'b01;
    localparam logic [1:0]  EV_REPEAT   = 2'b10;
    localparam logic [1:0]  EV_RELEASE  = 2'b11;
    localparam logic [25:0] HOLD_LAST   = 26'(HOLD_DELAY - 1);
    localparam logic [25:0] REPEAT_LAST = 26'(REPEAT_PERIOD - 1);

    state_t      state [4];
    logic [25:0] cnt [4];
    logic [3:0]  pend;
    logic [1:0]  pend_type [4];

    logic [3:0]  raise;
    logic [1:0]  raise_type [4];

    logic [3:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;

    logic        pop;
    logic        can_push;
    logic        push;
    logic [1:0]  grant_idx;
    logic [3:0]  grant;

    // Release wins over a timer expiring in the same cycle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            raise[i]      = 1'b0;
            raise_type[i] = EV_PRESS;
            case (state[i])
                IDLE: begin
                    if (clean[i]) begin
                        raise[i]      = 1'b1;
                        raise_type[i] = EV_PRESS;
                    end
                end
                WAIT: begin
                    if (!clean[i]) begin
                        raise[i]      = 1'b1;
                        raise_type[i] = EV_RELEASE;
                    end else if (cnt[i] == HOLD_LAST) begin
                        raise[i]      = 1'b1;
                        raise_type[i] = EV_REPEAT;
                    end
                end
                REPEAT: begin
                    if (!clean[i]) begin
                        raise[i]      = 1'b1;
                        raise_type[i] = EV_RELEASE;
                    end else if (cnt[i] == REPEAT_LAST) begin
                        raise[i]      = 1'b1;
                        raise_type[i] = EV_REPEAT;
                    end
                end
                default: begin
                    raise[i]      = 1'b0;
                    raise_type[i] = EV_PRESS;
                end
            endcase
        end
    end

    always_comb begin
        pop       = evt_valid && evt_ready;
        can_push  = (count < 3'd4) || pop;
        grant_idx = 2'd0;
        grant     = 4'd0;
        push      = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (pend[i]) begin
                grant_idx = 2'(i);
            end
        end
        if (can_push && (pend != 4'd0)) begin
            push             = 1'b1;
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state[i]     <= IDLE;
                cnt[i]       <= 26'd0;
                pend_type[i] <= 2'd0;
            end
            pend     <= 4'd0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (state[i])
                    IDLE: begin
                        if (clean[i]) begin
                            state[i] <= WAIT;
                            cnt[i]   <= 26'd0;
                        end
                    end
                    WAIT: begin
                        if (!clean[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= 26'd0;
                        end else if (cnt[i] == HOLD_LAST) begin
                            state[i] <= REPEAT;
                            cnt[i]   <= 26'd0;
                        end else begin
                            cnt[i] <= cnt[i] + 26'd1;
                        end
                    end
                    REPEAT: begin
                        if (!clean[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= 26'd0;
                        end else if (cnt[i] == REPEAT_LAST) begin
                            cnt[i] <= 26'd0;
                        end else begin
                            cnt[i] <= cnt[i] + 26'd1;
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= 26'd0;
                    end
                endcase

                // A granted old event leaves the slot free for the new one.
                if (raise[i]) begin
                    pend[i]      <= 1'b1;
                    pend_type[i] <= raise_type[i];
                    if (pend[i] && !grant[i]) begin
                        overflow <= 1'b1;
                    end
                end else if (grant[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= 4'd0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {pend_type[grant_idx], grant_idx};
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign evt_valid = (count != 3'd0);
    assign evt_code  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_button_sequencer.sv
// Bench for button_sequencer: directed scenarios with fixed expectations plus a
// random run compared every cycle against a hold-duration based event model.
module tb_button_sequencer;

    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] clean = 4'd0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [3:0] evt_code;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcycles = 0;

    logic [3:0] popped [$];
    int         pop_cyc [$];

    // reference model state
    int         held [4];
    bit         mpend [4];
    logic [1:0] mtype [4];
    logic [3:0] mq [$];
    bit         movf;

    button_sequencer #(.HOLD_DELAY(HOLD), .REPEAT_PERIOD(REP)) dut (
        .clock     (clock),
        .reset     (reset),
        .clean     (clean),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic model_update();
        int         g;
        bit         mpop;
        bit         can;
        bit         ev [4];
        logic [1:0] et [4];
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                held[i]  = 0;
                mpend[i] = 1'b0;
                mtype[i] = 2'd0;
            end
            mq.delete();
            movf = 1'b0;
            return;
        end
        mpop = (mq.size() != 0) && evt_ready;
        can  = (mq.size() < 4) || mpop;
        g = -1;
        for (int i = 0; i < 4; i++) begin
            if (mpend[i] && g < 0) g = i;
        end
        for (int i = 0; i < 4; i++) begin
            ev[i] = 1'b0;
            et[i] = 2'b00;
            if (clean[i]) begin
                if (held[i] == 0) begin
                    ev[i] = 1'b1; et[i] = 2'b01;
                end else if (held[i] >= HOLD && ((held[i] - HOLD) % REP) == 0) begin
                    ev[i] = 1'b1; et[i] = 2'b10;
                end
            end else if (held[i] > 0) begin
                ev[i] = 1'b1; et[i] = 2'b11;
            end
        end
        if (mpop) void'(mq.pop_front());
        if (can && g >= 0) begin
            mq.push_back({mtype[g], 2'(g)});
            mpend[g] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (ev[i]) begin
                if (mpend[i]) movf = 1'b1;
                mpend[i] = 1'b1;
                mtype[i] = et[i];
            end
            held[i] = clean[i] ? held[i] + 1 : 0;
        end
    endtask

    task automatic step();
        if (evt_valid) vcycles++;
        if (evt_valid && evt_ready) begin
            popped.push_back(evt_code);
            pop_cyc.push_back(cyc);
        end
        @(posedge clock);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clean = 4'd0;
        evt_ready = 1'b0;
        step();
        reset = 1'b0;
        popped.delete();
        pop_cyc.delete();
        vcycles = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clean = 4'd0;
        evt_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({evt_valid, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: valid,ovf got %b want 00", {evt_valid, overflow});
        end
        step();
        checks++;
        if ({evt_valid, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: valid,ovf got %b want 00", {evt_valid, overflow});
        end
    endtask

    task automatic test_single_press();
        do_reset();
        evt_ready = 1'b1;
        clean = 4'b0001;
        step();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_edge_k: valid got %b want 0", evt_valid);
        end
        step();
        checks++;
        if ({evt_valid, evt_code} !== 5'b1_0100) begin
            errors++;
            $display("FAIL single_edge_k1: valid,code got %b want 10100", {evt_valid, evt_code});
        end
        repeat (8) step();
        clean = 4'b0000;
        repeat (4) step();
        checks++;
        if (popped.size() !== 2 || popped[0] !== 4'b0100 || popped[1] !== 4'b1100) begin
            errors++;
            $display("FAIL single_events: got %0d events first %b second %b want 2 events 0100 1100",
                     popped.size(), popped[0], popped[1]);
        end
        checks++;
        if (vcycles !== 2) begin
            errors++;
            $display("FAIL single_valid_cycles: got %0d want 2", vcycles);
        end
    endtask

    task automatic test_hold_repeat();
        logic [3:0] exp_code [6];
        int         exp_gap [5];
        exp_code = '{4'b0110, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1110};
        exp_gap  = '{20, 5, 5, 5, 1};
        do_reset();
        evt_ready = 1'b1;
        clean = 4'b0100;
        repeat (36) step();
        clean = 4'b0000;
        repeat (4) step();
        checks++;
        if (popped.size() !== 6) begin
            errors++;
            $display("FAIL hold_count: got %0d events want 6", popped.size());
        end
        for (int i = 0; i < 6 && i < popped.size(); i++) begin
            checks++;
            if (popped[i] !== exp_code[i]) begin
                errors++;
                $display("FAIL hold_code[%0d]: got %b want %b", i, popped[i], exp_code[i]);
            end
        end
        for (int i = 0; i < 5 && i + 1 < pop_cyc.size(); i++) begin
            checks++;
            if (pop_cyc[i+1] - pop_cyc[i] !== exp_gap[i]) begin
                errors++;
                $display("FAIL hold_gap[%0d]: got %0d want %0d", i, pop_cyc[i+1] - pop_cyc[i], exp_gap[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_code [8];
        exp_code = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        do_reset();
        evt_ready = 1'b1;
        clean = 4'b1111;
        repeat (8) step();
        clean = 4'b0000;
        repeat (8) step();
        checks++;
        if (popped.size() !== 8) begin
            errors++;
            $display("FAIL simul_count: got %0d events want 8", popped.size());
        end
        for (int i = 0; i < 8 && i < popped.size(); i++) begin
            checks++;
            if (popped[i] !== exp_code[i]) begin
                errors++;
                $display("FAIL simul_code[%0d]: got %b want %b", i, popped[i], exp_code[i]);
            end
            if (i != 0 && i != 4) begin
                checks++;
                if (pop_cyc[i] - pop_cyc[i-1] !== 1) begin
                    errors++;
                    $display("FAIL simul_gap[%0d]: got %0d want 1", i, pop_cyc[i] - pop_cyc[i-1]);
                end
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL simul_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_code [5];
        exp_code = '{4'b0100, 4'b1100, 4'b0101, 4'b1101, 4'b1110};
        do_reset();
        evt_ready = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            clean = 4'(1 << ch);
            step();
            clean = 4'b0000;
            step();
        end
        repeat (3) step();
        checks++;
        if ({evt_valid, overflow} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_backpressure: valid,ovf got %b want 11", {evt_valid, overflow});
        end
        evt_ready = 1'b1;
        repeat (8) step();
        checks++;
        if (popped.size() !== 5) begin
            errors++;
            $display("FAIL ovf_drain_count: got %0d want 5", popped.size());
        end
        for (int i = 0; i < 5 && i < popped.size(); i++) begin
            checks++;
            if (popped[i] !== exp_code[i]) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got %b want %b", i, popped[i], exp_code[i]);
            end
        end
    endtask

    task automatic test_full_pop_push();
        logic [3:0] exp_code [6];
        exp_code = '{4'b0100, 4'b1100, 4'b0101, 4'b1101, 4'b0110, 4'b1110};
        do_reset();
        evt_ready = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            clean = 4'(1 << ch);
            step();
            clean = 4'b0000;
            step();
        end
        clean = 4'b0100;
        step();
        step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        step();
        checks++;
        if ({evt_valid, evt_code, overflow} !== 6'b1_1100_0) begin
            errors++;
            $display("FAIL full_popush_head: valid,code,ovf got %b want 111000", {evt_valid, evt_code, overflow});
        end
        clean = 4'b0000;
        step();
        step();
        evt_ready = 1'b1;
        repeat (8) step();
        checks++;
        if (popped.size() !== 6 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_popush_count: got %0d events ovf %b want 6 ovf 0", popped.size(), overflow);
        end
        for (int i = 0; i < 6 && i < popped.size(); i++) begin
            checks++;
            if (popped[i] !== exp_code[i]) begin
                errors++;
                $display("FAIL full_popush_order[%0d]: got %b want %b", i, popped[i], exp_code[i]);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        evt_ready = 1'b0;
        clean = 4'b0011;
        step();
        clean = 4'b0010;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({evt_valid, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_outputs: valid,ovf got %b want 00", {evt_valid, overflow});
        end
        popped.delete();
        pop_cyc.delete();
        evt_ready = 1'b1;
        step();
        step();
        checks++;
        if ({evt_valid, evt_code} !== 5'b1_0101) begin
            errors++;
            $display("FAIL midreset_press: valid,code got %b want 10101", {evt_valid, evt_code});
        end
        repeat (22) step();
        clean = 4'b0000;
        repeat (4) step();
        checks++;
        if (popped.size() !== 3 || popped[0] !== 4'b0101 || popped[1] !== 4'b1001 || popped[2] !== 4'b1101) begin
            errors++;
            $display("FAIL midreset_events: got %0d events %b %b %b want 0101 1001 1101",
                     popped.size(), popped[0], popped[1], popped[2]);
        end
        checks++;
        if (pop_cyc[1] - pop_cyc[0] !== 20) begin
            errors++;
            $display("FAIL midreset_repeat_gap: got %0d want 20", pop_cyc[1] - pop_cyc[0]);
        end
    endtask

    task automatic test_random();
        int         bias;
        logic [5:0] obs;
        logic [5:0] exp;
        do_reset();
        bias = 3;
        for (int n = 0; n < 4000; n++) begin
            if (n % 64 == 0) bias = $urandom_range(0, 4);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 11) == 0) clean[b] = ~clean[b];
            end
            evt_ready = ($urandom_range(0, 3) < bias);
            reset = ($urandom_range(0, 499) == 0);
            step();
            obs = {evt_valid, evt_valid ? evt_code : 4'd0, overflow};
            exp = {mq.size() != 0, (mq.size() != 0) ? mq[0] : 4'd0, movf};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_cycle %0d: valid,code,ovf got %b want %b", n, obs, exp);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold_repeat();
        test_simultaneous();
        test_overflow();
        test_full_pop_push();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
